ext_irq_ctrl: RTL and testbench

External interrupt controller that drives the core's machine external interrupt request (`meip`) and consumes its acknowledge (`irq_ack`). It collects up to `NUM_SRC` peripheral interrupt lines, latches them as pending (edge or level per source), selects the enabled pending source with the lowest ID, and holds `meip_o` high until the core acknowledges. Software configures and inspects it through a small word-addressed register port on the data bus.

---
 rtl/ext_irq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ext_irq_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ext_irq_ctrl
//  Description : External interrupt controller. Synchronises up to NUM_SRC
//                peripheral interrupt lines, latches them as pending (edge or
//                level per source), presents the lowest-ID enabled pending
//                source to the core on meip_o and holds it until irq_ack_i.
//                A word-addressed register port exposes ENABLE, PENDING,
//                EDGE and CLAIM.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        in   1        clock, rising edge
//    reset_i      in   1        synchronous reset, active low
//    src_i        in   NUM_SRC  asynchronous interrupt lines, active high
//    meip_o       out  1        machine external interrupt request
//    irq_ack_i    in   1        acknowledge from the core
//    irq_id_o     out  5        ID being requested, 0 = none
//    reg_we_i     in   1        register write strobe
//    reg_addr_i   in   2        0=ENABLE 1=PENDING 2=EDGE 3=CLAIM
//    reg_wdata_i  in   32       register write data
//    reg_rdata_o  out  32       registered read data
// ============================================================================
module ext_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               meip_o,
    input  logic               irq_ack_i,
    output logic [4:0]         irq_id_o,
    input  logic               reg_we_i,
    input  logic [1:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    localparam logic [1:0] c_ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] c_ADDR_PENDING = 2'd1;
    localparam logic [1:0] c_ADDR_EDGE    = 2'd2;
    localparam logic [1:0] c_ADDR_CLAIM   = 2'd3;

    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_s2_d;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_edge;
    logic [NUM_SRC-1:0] r_pending;
    logic [1:0]         r_state;
    logic [4:0]         r_irq_id;
    logic [31:0]        r_rdata;

    logic [NUM_SRC-1:0] w_event;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [NUM_SRC-1:0] w_w1c;
    logic [4:0]         w_win_id;
    logic               w_ack_fire;
    logic [1:0]         w_state_nxt;
    logic [31:0]        w_rdata;
    logic               w_unused_wdata;

    // Upper write-data bits have no storage behind them.
    assign w_unused_wdata = ^reg_wdata_i[31:NUM_SRC];

    // Per-source set event: rising edge or level depending on EDGE bit.
    assign w_event = (r_edge & r_s2 & ~r_s2_d) | (~r_edge & r_s2);
    assign w_req   = r_pending & r_enable;

    assign w_ack_fire = (r_state == c_ST_REQ) && irq_ack_i;

    assign w_w1c = (reg_we_i && (reg_addr_i == c_ADDR_PENDING))
                   ? reg_wdata_i[NUM_SRC-1:0] : '0;

    // Lowest index wins: scan downward so the last hit is the lowest bit.
    always_comb begin
        w_win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_id = 5'(i + 1);
            end
        end
    end

    // One-hot clear of the source being acknowledged.
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_clr[i] = w_ack_fire && (r_irq_id == 5'(i + 1));
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_win_id != 5'd0) w_state_nxt = c_ST_REQ;
            c_ST_REQ:  if (irq_ack_i)        w_state_nxt = c_ST_GAP;
            c_ST_GAP:                         w_state_nxt = c_ST_IDLE;
            default:                          w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ID is captured on entry to REQ and dropped on the acknowledge, so it
    // stays frozen while requesting even if the source is masked/cleared.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_irq_id <= '0;
        end else if ((r_state == c_ST_IDLE) && (w_win_id != 5'd0)) begin
            r_irq_id <= w_win_id;
        end else if (w_ack_fire || (r_state != c_ST_REQ)) begin
            r_irq_id <= '0;
        end
    end

    assign meip_o   = (r_state == c_ST_REQ);
    assign irq_id_o = r_irq_id;

    // ------------------------------------------------------------------
    // Synchronisers and configuration / pending registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s2_d    <= '0;
            r_enable  <= '0;
            r_edge    <= '0;
            r_pending <= '0;
        end else begin
            r_s1   <= src_i;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
            if (reg_we_i && (reg_addr_i == c_ADDR_ENABLE)) begin
                r_enable <= reg_wdata_i[NUM_SRC-1:0];
            end
            if (reg_we_i && (reg_addr_i == c_ADDR_EDGE)) begin
                r_edge <= reg_wdata_i[NUM_SRC-1:0];
            end
            // Set is OR-ed in after the clear so a coincident event wins.
            r_pending <= (r_pending & ~(w_ack_clr | w_w1c)) | w_event;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (reg_addr_i)
            c_ADDR_ENABLE:  w_rdata = {{(32-NUM_SRC){1'b0}}, r_enable};
            c_ADDR_PENDING: w_rdata = {{(32-NUM_SRC){1'b0}}, r_pending};
            c_ADDR_EDGE:    w_rdata = {{(32-NUM_SRC){1'b0}}, r_edge};
            c_ADDR_CLAIM:   w_rdata = {27'd0, r_irq_id};
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign reg_rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ext_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_irq_ctrl
//  Description : Self-checking bench for ext_irq_ctrl. Expected request IDs
//                are queued as stimulus is applied and popped when meip_o
//                rises; register reads and latencies are compared inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_irq_ctrl;

    localparam int NUM_SRC = 8;

    logic               clk_i;
    logic               reset_i;
    logic [NUM_SRC-1:0] src_i;
    logic               meip_o;
    logic               irq_ack_i;
    logic [4:0]         irq_id_o;
    logic               reg_we_i;
    logic [1:0]         reg_addr_i;
    logic [31:0]        reg_wdata_i;
    logic [31:0]        reg_rdata_o;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    ext_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .src_i       (src_i),
        .meip_o      (meip_o),
        .irq_ack_i   (irq_ack_i),
        .irq_id_o    (irq_id_o),
        .reg_we_i    (reg_we_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // All stimulus changes and all sampling happen on the falling edge.
    task automatic reset_dut();
        reset_i = 1'b0; src_i = '0; irq_ack_i = 1'b0;
        reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
        reg_we_i = 1'b1; reg_addr_i = addr; reg_wdata_i = data;
        @(negedge clk_i);
        reg_we_i = 1'b0; reg_wdata_i = '0;
    endtask

    task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
        reg_addr_i = addr;
        @(negedge clk_i);
        data = reg_rdata_o;
    endtask

    task automatic wait_meip(input int max, output int n);
        n = 0;
        while (!meip_o && n < max) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic do_ack();
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
    endtask

    task automatic pulse_src(input logic [NUM_SRC-1:0] bits);
        src_i = bits;
        @(negedge clk_i);
        src_i = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] rd;
        int n, e;
        reset_i = 1'b0; src_i = 8'hFF; irq_ack_i = 1'b0;
        reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
        repeat (3) @(negedge clk_i);
        total++;
        if (meip_o !== 1'b0 || irq_id_o !== 5'd0) begin
            bad++; $display("FAIL reset_out: meip=%b id=%0d want meip=0 id=0", meip_o, irq_id_o);
        end
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), rd);
            total++;
            if (rd !== 32'h0) begin
                bad++; $display("FAIL reset_reg%0d: got %h want 00000000", a, rd);
            end
        end
        // Release and enable on the same falling edge; first source sample
        // is the next rising edge, request three edges after that.
        reset_i = 1'b1;
        exp_q.push_back(1);
        reg_write(2'd0, 32'h0000_00FF);
        wait_meip(20, n);
        total++;
        if (n !== 3) begin
            bad++; $display("FAIL reset_latency: got %0d want 3", n);
        end
        e = exp_q.pop_front();
        total++;
        if (irq_id_o !== 5'(e)) begin
            bad++; $display("FAIL reset_first_id: got %0d want %0d", irq_id_o, e);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority();
        logic [31:0] rd;
        int n, e;
        reset_dut();
        reg_write(2'd2, 32'hFFFF_FFFF);
        reg_write(2'd0, 32'h0000_00FF);
        reg_read(2'd2, rd);
        total++;
        if (rd !== 32'h0000_00FF) begin
            bad++; $display("FAIL prio_edge_rd: got %h want 000000ff", rd);
        end
        exp_q.push_back(3);
        exp_q.push_back(6);
        pulse_src(8'h24);
        wait_meip(20, n);
        e = exp_q.pop_front();
        total++;
        if (!meip_o || irq_id_o !== 5'(e)) begin
            bad++; $display("FAIL prio_first: meip=%b id=%0d want meip=1 id=%0d", meip_o, irq_id_o, e);
        end
        reg_read(2'd3, rd);
        total++;
        if (rd !== 32'd3) begin
            bad++; $display("FAIL prio_claim: got %h want 00000003", rd);
        end
        reg_read(2'd1, rd);
        total++;
        if (rd !== 32'h24) begin
            bad++; $display("FAIL prio_pending: got %h want 00000024", rd);
        end
        do_ack();
        total++;
        if (meip_o !== 1'b0 || irq_id_o !== 5'd0) begin
            bad++; $display("FAIL prio_gap: meip=%b id=%0d want meip=0 id=0", meip_o, irq_id_o);
        end
        wait_meip(20, n);
        total++;
        if (n !== 2) begin
            bad++; $display("FAIL prio_rearm: got %0d want 2", n);
        end
        e = exp_q.pop_front();
        total++;
        if (irq_id_o !== 5'(e)) begin
            bad++; $display("FAIL prio_second: got %0d want %0d", irq_id_o, e);
        end
        do_ack();
        reg_read(2'd1, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL prio_pend_clr: got %h want 00000000", rd);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mask();
        logic [31:0] rd;
        int n, e;
        logic seen;
        reset_dut();
        reg_write(2'd2, 32'h0000_0001);
        pulse_src(8'h01);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (meip_o) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mask_no_req: got meip=1 want meip=0");
        end
        reg_write(2'd1, 32'h0);
        reg_read(2'd1, rd);
        total++;
        if (rd !== 32'h1) begin
            bad++; $display("FAIL mask_pending: got %h want 00000001", rd);
        end
        exp_q.push_back(1);
        reg_write(2'd0, 32'h0000_0001);
        wait_meip(20, n);
        total++;
        if (n !== 1) begin
            bad++; $display("FAIL mask_enable_lat: got %0d want 1", n);
        end
        e = exp_q.pop_front();
        total++;
        if (irq_id_o !== 5'(e)) begin
            bad++; $display("FAIL mask_id: got %0d want %0d", irq_id_o, e);
        end
        do_ack();
    endtask

    // ------------------------------------------------------------------
    task automatic test_set_beats_clear();
        logic [31:0] rd;
        int n, e;
        reset_dut();
        reg_write(2'd2, 32'h1);
        reg_write(2'd0, 32'h1);
        exp_q.push_back(1);
        pulse_src(8'h01);
        wait_meip(20, n);
        e = exp_q.pop_front();
        total++;
        if (!meip_o || irq_id_o !== 5'(e)) begin
            bad++; $display("FAIL sbc_first: meip=%b id=%0d want meip=1 id=%0d", meip_o, irq_id_o, e);
        end
        // New rising edge lands in PENDING on the same edge as the ack.
        src_i = 8'h01;
        @(negedge clk_i);
        src_i = '0;
        @(negedge clk_i);
        exp_q.push_back(1);
        do_ack();
        reg_read(2'd1, rd);
        total++;
        if (rd !== 32'h1) begin
            bad++; $display("FAIL sbc_pending: got %h want 00000001", rd);
        end
        wait_meip(20, n);
        total++;
        if (n !== 1) begin
            bad++; $display("FAIL sbc_rearm: got %0d want 1", n);
        end
        e = exp_q.pop_front();
        total++;
        if (irq_id_o !== 5'(e)) begin
            bad++; $display("FAIL sbc_second: got %0d want %0d", irq_id_o, e);
        end
        do_ack();
    endtask

    // ------------------------------------------------------------------
    task automatic test_level_w1c();
        logic [31:0] rd;
        int n, e;
        logic seen;
        reset_dut();
        reg_write(2'd0, 32'hFF);
        src_i = 8'h08;
        exp_q.push_back(4);
        wait_meip(20, n);
        e = exp_q.pop_front();
        total++;
        if (irq_id_o !== 5'(e)) begin
            bad++; $display("FAIL lvl_first: got %0d want %0d", irq_id_o, e);
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4);
            do_ack();
            wait_meip(20, n);
            total++;
            if (n !== 2) begin
                bad++; $display("FAIL lvl_spacing%0d: got %0d want 2", k, n);
            end
            e = exp_q.pop_front();
            total++;
            if (irq_id_o !== 5'(e)) begin
                bad++; $display("FAIL lvl_id%0d: got %0d want %0d", k, irq_id_o, e);
            end
        end
        src_i = '0;
        repeat (3) @(negedge clk_i);
        reg_write(2'd1, 32'h08);
        total++;
        if (meip_o !== 1'b1 || irq_id_o !== 5'd4) begin
            bad++; $display("FAIL lvl_no_retract: meip=%b id=%0d want meip=1 id=4", meip_o, irq_id_o);
        end
        do_ack();
        reg_read(2'd1, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL lvl_w1c: got %h want 00000000", rd);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (meip_o) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL lvl_quiet: got meip=1 want meip=0");
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_req();
        logic [31:0] rd;
        int n, e;
        reset_dut();
        reg_write(2'd2, 32'hFF);
        reg_write(2'd0, 32'hFF);
        exp_q.push_back(2);
        pulse_src(8'h02);
        wait_meip(20, n);
        e = exp_q.pop_front();
        total++;
        if (!meip_o || irq_id_o !== 5'(e)) begin
            bad++; $display("FAIL rmr_req: meip=%b id=%0d want meip=1 id=%0d", meip_o, irq_id_o, e);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (meip_o !== 1'b0 || irq_id_o !== 5'd0) begin
            bad++; $display("FAIL rmr_out: meip=%b id=%0d want meip=0 id=0", meip_o, irq_id_o);
        end
        reset_i = 1'b1;
        reg_read(2'd1, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL rmr_pending: got %h want 00000000", rd);
        end
        reg_read(2'd0, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL rmr_enable: got %h want 00000000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mask();
        test_set_beats_clear();
        test_level_w1c();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
